// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg
// Description : Shared definitions for the PPU VRAM access path: register
//               indices, access FSM encoding, target decode and region bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    // CPU-visible register indices (low three address bits)
    localparam logic [2:0] c_PPUSTATUS = 3'd2;
    localparam logic [2:0] c_PPUADDR   = 3'd6;
    localparam logic [2:0] c_PPUDATA   = 3'd7;

    // Access FSM encoding
    typedef logic [1:0] fsm_t;
    localparam fsm_t c_IDLE = 2'd0;
    localparam fsm_t c_WR   = 2'd1;
    localparam fsm_t c_RD   = 2'd2;

    // Which memory a PPU address lands in
    typedef enum logic [1:0] {
        T_CHR  = 2'd0,
        T_VRAM = 2'd1,
        T_PAL  = 2'd2
    } target_t;

    // Region boundaries in the 14-bit PPU address space
    localparam logic [13:0] c_VRAM_BASE = 14'h2000;
    localparam logic [13:0] c_PAL_BASE  = 14'h3F00;

    // Sprite palette entry 0 of each group ($3F10/14/18/1C) aliases the
    // matching background entry.
    function automatic logic [4:0] pal_fold(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_vram_port_if.sv
`default_nettype none
// ============================================================================
// Module      : ppu_vram_port_if
// Description : CPU register bus between the PPU register file (master) and
//               the VRAM access port (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ppu_vram_port_if;
    logic       reg_en;
    logic       reg_we;
    logic [2:0] reg_sel;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output reg_en, reg_we, reg_sel, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_en, reg_we, reg_sel, reg_wdata,
        output reg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ppu_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : ppu_addr_map
// Description : Combinational decode of a 14-bit PPU address into a target
//               memory plus the CHR, folded VRAM and folded palette addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_addr_map
    import ppu_pkg::*;
#(
    parameter int VRAM_AW = 11,
    parameter int CHR_AW  = 13
) (
    input  wire logic [13:0]        i_v,
    input  wire logic               i_mirror_v,
    output target_t                 o_target,
    output logic [VRAM_AW-1:0]      o_vram_addr,
    output logic [CHR_AW-1:0]       o_chr_addr,
    output logic [4:0]              o_pal_addr
);

    // Region select: pattern tables, nametables (incl. $3000 alias), palette
    always_comb begin
        if (i_v < c_VRAM_BASE) begin
            o_target = T_CHR;
        end else if (i_v < c_PAL_BASE) begin
            o_target = T_VRAM;
        end else begin
            o_target = T_PAL;
        end
    end

    // Two physical nametables: vertical mirroring picks by bit 10,
    // horizontal by bit 11. Bits 13:12 are dropped, so $3xxx aliases $2xxx
    // and a palette address already yields the nametable underneath it.
    assign o_vram_addr = {(i_mirror_v ? i_v[10] : i_v[11]), i_v[9:0]};
    assign o_chr_addr  = i_v[CHR_AW-1:0];
    assign o_pal_addr  = pal_fold(i_v[4:0]);

endmodule
`default_nettype wire

// File: rtl/ppu_vram_port.sv
`default_nettype none
// ============================================================================
// Module      : ppu_vram_port
// Description : CPU-side PPUADDR/PPUDATA access path to nametable VRAM, with
//               pass-through CHR and palette ports. Two-write address latch,
//               one-behind buffered reads, +1/+32 auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int VRAM_AW = 11,
    parameter int CHR_AW  = 13
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               clk_en,
    ppu_vram_port_if.slave          bus,
    input  wire logic               inc32,
    input  wire logic               mirror_v,
    output logic [VRAM_AW-1:0]      vram_addr,
    output logic                    vram_we,
    output logic [7:0]              vram_wdata,
    input  wire logic [7:0]         vram_rdata,
    output logic [CHR_AW-1:0]       chr_addr,
    input  wire logic [7:0]         chr_rdata,
    output logic [4:0]              pal_addr,
    output logic                    pal_we,
    output logic [7:0]              pal_wdata,
    input  wire logic [7:0]         pal_rdata,
    output logic                    busy,
    output logic                    overrun
);

    logic [13:0] r_v;
    logic [13:0] r_t;
    logic        r_w;
    logic [7:0]  r_rbuf;
    logic [7:0]  r_wdata;
    fsm_t        r_fsm;
    logic        r_busy;
    logic        r_overrun;
    logic        r_load_pend;
    logic [13:0] r_load_val;

    target_t     w_target;
    logic        w_idle;
    logic        w_addr_wr;
    logic        w_status_rd;
    logic        w_data_acc;
    logic        w_start_wr;
    logic        w_start_rd;
    logic        w_vload;
    logic [13:0] w_t_next;
    logic [13:0] w_v_inc;
    logic [7:0]  w_fill;
    logic [7:0]  w_rdata;

    ppu_addr_map #(
        .VRAM_AW (VRAM_AW),
        .CHR_AW  (CHR_AW)
    ) u_map (
        .i_v         (r_v),
        .i_mirror_v  (mirror_v),
        .o_target    (w_target),
        .o_vram_addr (vram_addr),
        .o_chr_addr  (chr_addr),
        .o_pal_addr  (pal_addr)
    );

    assign w_idle      = (r_fsm == c_IDLE);
    assign w_addr_wr   = bus.reg_en &  bus.reg_we & (bus.reg_sel == c_PPUADDR);
    assign w_status_rd = bus.reg_en & ~bus.reg_we & (bus.reg_sel == c_PPUSTATUS);
    assign w_data_acc  = bus.reg_en & (bus.reg_sel == c_PPUDATA);
    assign w_start_wr  = w_data_acc &  bus.reg_we & w_idle;
    assign w_start_rd  = w_data_acc & ~bus.reg_we & w_idle;
    assign w_vload     = w_addr_wr & r_w;

    // The second PPUADDR write copies the freshly completed t into v, so
    // build the updated t here and use it for both registers.
    always_comb begin
        w_t_next = r_t;
        if (w_addr_wr) begin
            if (!r_w) begin
                w_t_next[13:8] = bus.reg_wdata[5:0];
            end else begin
                w_t_next[7:0] = bus.reg_wdata;
            end
        end
    end

    // 14-bit add wraps $3FFF -> $0000 on its own
    assign w_v_inc = r_v + (inc32 ? 14'd32 : 14'd1);

    // Read-buffer fill: palette reads take the nametable underneath, which
    // is exactly what vram_addr already points at for a palette address.
    assign w_fill = (w_target == T_CHR) ? chr_rdata : vram_rdata;

    // PPUDATA read returns the buffered byte, except palette which is direct
    always_comb begin
        w_rdata = 8'h00;
        if (w_start_rd) begin
            w_rdata = (w_target == T_PAL) ? pal_rdata : r_rbuf;
        end
    end
    assign bus.reg_rdata = w_rdata;

    // Write strobes last exactly the commit cycle; CHR writes are dropped
    assign vram_we    = (r_fsm == c_WR) & clk_en & (w_target == T_VRAM);
    assign pal_we     = (r_fsm == c_WR) & clk_en & (w_target == T_PAL);
    assign vram_wdata = r_wdata;
    assign pal_wdata  = r_wdata;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

    // Address latch, access FSM, read buffer and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v         <= 14'h0000;
            r_t         <= 14'h0000;
            r_w         <= 1'b0;
            r_rbuf      <= 8'h00;
            r_wdata     <= 8'h00;
            r_fsm       <= c_IDLE;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_load_pend <= 1'b0;
            r_load_val  <= 14'h0000;
        end else begin
            if (w_addr_wr) begin
                r_t <= w_t_next;
                r_w <= ~r_w;
            end
            if (w_status_rd) begin
                r_w <= 1'b0;
            end
            if (w_data_acc && !w_idle) begin
                r_overrun <= 1'b1;
            end

            case (r_fsm)
                c_IDLE: begin
                    if (w_vload) begin
                        r_v <= w_t_next;
                    end
                    if (w_start_wr) begin
                        r_wdata <= bus.reg_wdata;
                        r_fsm   <= c_WR;
                        r_busy  <= 1'b1;
                    end else if (w_start_rd) begin
                        r_fsm   <= c_RD;
                        r_busy  <= 1'b1;
                    end
                end
                c_WR, c_RD: begin
                    // v must stay put until the commit; park any reload
                    if (w_vload && !clk_en) begin
                        r_load_pend <= 1'b1;
                        r_load_val  <= w_t_next;
                    end
                    if (clk_en) begin
                        if (r_fsm == c_RD) begin
                            r_rbuf <= w_fill;
                        end
                        if (w_vload) begin
                            r_v <= w_t_next;
                        end else if (r_load_pend) begin
                            r_v <= r_load_val;
                        end else begin
                            r_v <= w_v_inc;
                        end
                        r_load_pend <= 1'b0;
                        r_fsm       <= c_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_fsm  <= c_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
